// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display scheduler.
//   seg7_t    : one 7-segment pattern, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_*     : glyph encodings for 0..F plus the all-off blank pattern
//   state_e   : scheduler FSM states
package hex_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'h40;
  localparam seg7_t SEG_1     = 7'h79;
  localparam seg7_t SEG_2     = 7'h24;
  localparam seg7_t SEG_3     = 7'h30;
  localparam seg7_t SEG_4     = 7'h19;
  localparam seg7_t SEG_5     = 7'h12;
  localparam seg7_t SEG_6     = 7'h02;
  localparam seg7_t SEG_7     = 7'h78;
  localparam seg7_t SEG_8     = 7'h00;
  localparam seg7_t SEG_9     = 7'h18;
  localparam seg7_t SEG_A     = 7'h08;
  localparam seg7_t SEG_B     = 7'h03;
  localparam seg7_t SEG_C     = 7'h46;
  localparam seg7_t SEG_D     = 7'h21;
  localparam seg7_t SEG_E     = 7'h06;
  localparam seg7_t SEG_F     = 7'h0E;
  localparam seg7_t SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_nibble_dec.sv
// Combinational nibble -> 7-segment decoder (active-low).
//   nib_i : 4-bit hex digit
//   seg_o : segment pattern {g..a}
module seg7_nibble_dec
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Multi-digit hex display driver. Accepts a value over valid/ready, decodes
// it one digit per clock (MS digit first) through a single shared decoder
// into a shadow bank, then copies the whole bank to the pins in one commit
// cycle so the display never shows a half-updated value.
//
// Optional feature macro: HEX_BLINK_EN (adds in_blink and a blink prescaler).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : new value offered
//   in_ready     : high while IDLE (can accept)
//   in_value     : nibble i drives digit i (digit 0 rightmost)
//   in_lz_blank  : blank leading zeros for this value
//   in_blink     : per-digit blink mask (HEX_BLINK_EN only)
//   hex_o        : active-low segments, digit i at [7i+6:7i]
//   busy         : high in SCAN or COMMIT
//   done         : one-cycle pulse with the first cycle showing the new value
module hex_display_scheduler
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int BLINK_DIV_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_lz_blank,
`ifdef HEX_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   in_blink,
`endif
  output logic [7*NUM_DIGITS-1:0] hex_o,
  output logic                    busy,
  output logic                    done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV_W < 1) begin : g_bad_div
    $error("BLINK_DIV_W must be >= 1");
  end

  state_e                       state_q;
  logic [4*NUM_DIGITS-1:0]      val_q;
  logic                         lz_q;
  logic [IDX_W-1:0]             idx_q;
  logic                         seen_nz_q;
  logic [NUM_DIGITS-1:0][6:0]   shadow_q;
  logic [NUM_DIGITS-1:0][6:0]   hex_q;
  logic                         done_q;
`ifdef HEX_BLINK_EN
  logic [NUM_DIGITS-1:0]        blink_in_q;  // captured with the value
  logic [NUM_DIGITS-1:0]        blink_q;     // committed mask
  logic [BLINK_DIV_W-1:0]       presc_q;
`endif

  logic [3:0] nib;
  seg7_t      dec_seg;
  seg7_t      seg_d;

  assign nib = val_q[idx_q*4 +: 4];

  // The one shared decoder; the FSM walks idx_q across the captured value.
  seg7_nibble_dec u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // Leading-zero blanking: only zeros ahead of the first non-zero digit,
  // and never digit 0 so a zero value still shows "0".
  always_comb begin
    seg_d = dec_seg;
    if (lz_q && !seen_nz_q && nib == 4'h0 && idx_q != '0) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      val_q     <= '0;
      lz_q      <= 1'b0;
      idx_q     <= '0;
      seen_nz_q <= 1'b0;
      shadow_q  <= {NUM_DIGITS{SEG_BLANK}};
      hex_q     <= {NUM_DIGITS{SEG_BLANK}};
      done_q    <= 1'b0;
`ifdef HEX_BLINK_EN
      blink_in_q <= '0;
      blink_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            val_q     <= in_value;
            lz_q      <= in_lz_blank;
            idx_q     <= IDX_LAST;
            seen_nz_q <= 1'b0;
`ifdef HEX_BLINK_EN
            blink_in_q <= in_blink;
`endif
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          shadow_q[idx_q] <= seg_d;
          if (nib != 4'h0) seen_nz_q <= 1'b1;
          if (idx_q == '0) state_q <= COMMIT;
          else             idx_q   <= idx_q - 1'b1;
        end
        COMMIT: begin
          hex_q   <= shadow_q;
          done_q  <= 1'b1;
`ifdef HEX_BLINK_EN
          blink_q <= blink_in_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SCAN) || (state_q == COMMIT);
  assign done     = done_q;

`ifdef HEX_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_blink
    assign hex_o[7*i +: 7] = (blink_q[i] && presc_q[BLINK_DIV_W-1]) ? SEG_BLANK : hex_q[i];
  end
`else
  assign hex_o = hex_q;
`endif

endmodule
